// File: rtl/e203_exu_wbck_arb_if.sv
// Write-back bundle between the EU sources, the write-back arbiter and the
// integer regfile write ports.
interface e203_exu_wbck_arb_if #(
    parameter int NSRC    = 4,
    parameter int NWP     = 2,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
);
    logic [NSRC-1:0]         src_valid;
    logic [NSRC-1:0]         src_ready;
    logic [NSRC-1:0]         src_prio;
    logic [NSRC*XLEN-1:0]    src_wdat;
    logic [NSRC*RFIDX_W-1:0] src_rdidx;
    logic [NSRC-1:0]         src_rdfpu;
    logic [NWP-1:0]          rf_wbck_o_ena;
    logic [NWP*XLEN-1:0]     rf_wbck_o_wdat;
    logic [NWP*RFIDX_W-1:0]  rf_wbck_o_rdidx;

    modport master (
        output src_valid, src_prio, src_wdat, src_rdidx, src_rdfpu,
        input  src_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
    );

    modport slave (
        input  src_valid, src_prio, src_wdat, src_rdidx, src_rdfpu,
        output src_ready, rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
    );
endinterface

// File: rtl/e203_exu_wbck_arb.sv
// N-source, NWP-port regfile write-back arbiter with priority classes, round-robin and starvation promotion.
// Optional macro E203_WBCK_ARB_OUTREG_EN registers the regfile write outputs (one cycle after the handshake).
module e203_exu_wbck_arb #(
    parameter int NSRC       = 4,
    parameter int NWP        = 2,
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int STARVE_MAX = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    e203_exu_wbck_arb_if.slave   wb,
    output logic                 arb_starve_o
);
    localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       wait_cnt_q [NSRC];
    logic [CNT_W-1:0]       wait_cnt_d [NSRC];
    logic [NSRC-1:0]        req, promoted, granted;
    logic [NWP-1:0]         port_ena_d;
    logic [NWP*XLEN-1:0]    port_wdat_d;
    logic [NWP*RFIDX_W-1:0] port_rdidx_d;

    logic [PTR_W-1:0]       cand [NSRC];
    logic [NSRC-1:0]        cand_c3;
    int                     ncand, slot, idx, j;
    logic [RFIDX_W-1:0]     rd, first_rd;
    logic                   hz, first_hz, rr_hit;
    logic [PTR_W-1:0]       rr_last;

    assign req = wb.src_valid & {NSRC{~rst}};

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            promoted[i] = req[i] & ~wb.src_prio[i] & (wait_cnt_q[i] == STARVE_LIM);
        end
    end

    // Candidates are listed in grant order: promoted, high-priority, then round-robin normals.
    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            cand[k] = '0;
        end
        cand_c3 = '0;
        ncand   = 0;
        idx     = 0;
        for (int i = 0; i < NSRC; i++) begin
            if (promoted[i]) begin
                cand[ncand] = PTR_W'(i);
                ncand++;
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (req[i] && wb.src_prio[i]) begin
                cand[ncand] = PTR_W'(i);
                ncand++;
            end
        end
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (req[idx] && !wb.src_prio[idx] && !promoted[idx]) begin
                cand[ncand]    = PTR_W'(idx);
                cand_c3[ncand] = 1'b1;
                ncand++;
            end
        end
    end

    // A hazard-blocked candidate still consumes its port; later candidates do not backfill it.
    always_comb begin
        granted      = '0;
        port_ena_d   = '0;
        port_wdat_d  = '0;
        port_rdidx_d = '0;
        slot         = 0;
        j            = 0;
        rd           = '0;
        hz           = 1'b0;
        first_rd     = '0;
        first_hz     = 1'b0;
        rr_hit       = 1'b0;
        rr_last      = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (k < ncand && slot < NWP) begin
                j  = int'(cand[k]);
                rd = wb.src_rdidx[j*RFIDX_W +: RFIDX_W];
                hz = ~wb.src_rdfpu[j] & (rd != '0);
                if (!(slot > 0 && hz && first_hz && rd == first_rd)) begin
                    granted[j]                               = 1'b1;
                    port_ena_d[slot]                         = hz;
                    port_wdat_d[slot*XLEN +: XLEN]           = wb.src_wdat[j*XLEN +: XLEN];
                    port_rdidx_d[slot*RFIDX_W +: RFIDX_W]    = rd;
                    if (cand_c3[k]) begin
                        rr_hit  = 1'b1;
                        rr_last = cand[k];
                    end
                    if (slot == 0) begin
                        first_rd = rd;
                        first_hz = hz;
                    end
                end
                slot++;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rr_hit) begin
            rr_ptr_d = (int'(rr_last) + 1 >= NSRC) ? '0 : rr_last + PTR_W'(1);
        end
        for (int i = 0; i < NSRC; i++) begin
            if (wb.src_prio[i] || !wb.src_valid[i] || granted[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] < STARVE_LIM) begin
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
            end else begin
                wait_cnt_d[i] = STARVE_LIM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NSRC; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign wb.src_ready = granted;
    assign arb_starve_o = |promoted;

`ifdef E203_WBCK_ARB_OUTREG_EN
    logic [NWP-1:0]         port_ena_q;
    logic [NWP*XLEN-1:0]    port_wdat_q;
    logic [NWP*RFIDX_W-1:0] port_rdidx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            port_ena_q   <= '0;
            port_wdat_q  <= '0;
            port_rdidx_q <= '0;
        end else begin
            port_ena_q   <= port_ena_d;
            port_wdat_q  <= port_wdat_d;
            port_rdidx_q <= port_rdidx_d;
        end
    end

    assign wb.rf_wbck_o_ena   = port_ena_q;
    assign wb.rf_wbck_o_wdat  = port_wdat_q;
    assign wb.rf_wbck_o_rdidx = port_rdidx_q;
`else
    assign wb.rf_wbck_o_ena   = port_ena_d;
    assign wb.rf_wbck_o_wdat  = port_wdat_d;
    assign wb.rf_wbck_o_rdidx = port_rdidx_d;
`endif
endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Scoreboard bench for the write-back arbiter: directed cycles push hand-derived expectations,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_e203_exu_wbck_arb;
    localparam int NSRC       = 4;
    localparam int NWP        = 2;
    localparam int XLEN       = 32;
    localparam int RFIDX_W    = 5;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arbStarve;

    always #5 clk = ~clk;

    e203_exu_wbck_arb_if #(.NSRC(NSRC), .NWP(NWP), .XLEN(XLEN), .RFIDX_W(RFIDX_W)) wbIf ();

    e203_exu_wbck_arb #(
        .NSRC(NSRC), .NWP(NWP), .XLEN(XLEN), .RFIDX_W(RFIDX_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb(wbIf),
        .arb_starve_o(arbStarve)
    );

    typedef struct packed {
        logic [3:0] ready;
        logic [1:0] ena;
        logic [1:0] src0;
        logic [1:0] src1;
        logic [4:0] rd0;
        logic [4:0] rd1;
        logic       starve;
    } expT;

    expT sbQ[$];
    expT prevExp = '0;
    int  errCount   = 0;
    int  checkCount = 0;

    function automatic logic [31:0] wdatOf(input logic [1:0] s);
        return {24'hC0DE5A, 6'd0, s};
    endfunction

    function automatic logic [19:0] rd4(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] d);
        return {d, c, b, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic [3:0] valid, input logic [3:0] prio,
                                 input logic [3:0] fpu, input logic [19:0] rds,
                                 input logic [3:0] expReady, input logic [1:0] expEna,
                                 input logic [1:0] expSrc0, input logic [1:0] expSrc1,
                                 input logic expStarve);
        expT e;
        @(posedge clk);
        #1;
        rst                = rstIn;
        wbIf.src_valid     = valid;
        wbIf.src_prio      = prio;
        wbIf.src_rdfpu     = fpu;
        wbIf.src_rdidx     = rds;
        wbIf.src_wdat      = {wdatOf(2'd3), wdatOf(2'd2), wdatOf(2'd1), wdatOf(2'd0)};
        e.ready  = expReady;
        e.ena    = expEna;
        e.src0   = expSrc0;
        e.src1   = expSrc1;
        e.rd0    = rds[expSrc0*5 +: 5];
        e.rd1    = rds[expSrc1*5 +: 5];
        e.starve = expStarve;
        sbQ.push_back(e);
    endtask

    // Monitor: compare mid-cycle; with registered outputs the RF fields lag one cycle.
    always @(negedge clk) begin
        expT e;
        expT r;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
`ifdef E203_WBCK_ARB_OUTREG_EN
            r = prevExp;
`else
            r = e;
`endif
            checkOutput("src_ready", 32'(wbIf.src_ready), 32'(e.ready));
            checkOutput("arb_starve", 32'(arbStarve), 32'(e.starve));
            checkOutput("rf_ena", 32'(wbIf.rf_wbck_o_ena), 32'(r.ena));
            if (r.ena[0]) begin
                checkOutput("port0_rdidx", 32'(wbIf.rf_wbck_o_rdidx[4:0]), 32'(r.rd0));
                checkOutput("port0_wdat", wbIf.rf_wbck_o_wdat[31:0], wdatOf(r.src0));
            end
            if (r.ena[1]) begin
                checkOutput("port1_rdidx", 32'(wbIf.rf_wbck_o_rdidx[9:5]), 32'(r.rd1));
                checkOutput("port1_wdat", wbIf.rf_wbck_o_wdat[63:32], wdatOf(r.src1));
            end
            prevExp = e;
        end
    end

    initial begin
        wbIf.src_valid = '0;
        wbIf.src_prio  = '0;
        wbIf.src_rdfpu = '0;
        wbIf.src_rdidx = '0;
        wbIf.src_wdat  = '0;

        // Reset held two cycles with all sources requesting
        applyStimulus(1, 4'hF, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b0000, 2'b00, 0, 0, 0);
        applyStimulus(1, 4'hF, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b0000, 2'b00, 0, 0, 0);
        // Round-robin from pointer 0, then 2
        applyStimulus(0, 4'hF, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b0011, 2'b11, 0, 1, 0);
        applyStimulus(0, 4'hF, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b1100, 2'b11, 2, 3, 0);
        applyStimulus(0, 4'h0, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b0000, 2'b00, 0, 0, 0);
        // High-priority source first, src2 waits then wins
        applyStimulus(0, 4'b0111, 4'b0001, 4'h0, rd4(3, 4, 5, 6), 4'b0011, 2'b11, 0, 1, 0);
        applyStimulus(0, 4'b0100, 4'b0001, 4'h0, rd4(3, 4, 5, 6), 4'b0100, 2'b01, 2, 0, 0);
        // Same-rdidx hazard: port 1 idles, loser wins next cycle on port 0
        applyStimulus(0, 4'b0011, 4'h0, 4'h0, rd4(7, 7, 1, 2), 4'b0001, 2'b01, 0, 0, 0);
        applyStimulus(0, 4'b0011, 4'h0, 4'h0, rd4(7, 7, 1, 2), 4'b0010, 2'b01, 1, 0, 0);
        applyStimulus(0, 4'h0, 4'h0, 4'h0, rd4(7, 7, 1, 2), 4'b0000, 2'b00, 0, 0, 0);
        // Starvation: src3 promoted on the fourth cycle
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 4'b1011, 4'b0011, 4'h0, rd4(1, 2, 5, 8), 4'b0011, 2'b11, 0, 1, 0);
        end
        applyStimulus(0, 4'b1011, 4'b0011, 4'h0, rd4(1, 2, 5, 8), 4'b1001, 2'b11, 3, 0, 1);
        applyStimulus(0, 4'b1011, 4'b0011, 4'h0, rd4(1, 2, 5, 8), 4'b0011, 2'b11, 0, 1, 0);
        applyStimulus(0, 4'h0, 4'h0, 4'h0, rd4(1, 2, 5, 8), 4'b0000, 2'b00, 0, 0, 0);
        // Consumed without write: x0 target, then FP target
        applyStimulus(0, 4'b0100, 4'h0, 4'h0, rd4(1, 2, 0, 4), 4'b0100, 2'b00, 2, 0, 0);
        applyStimulus(0, 4'b0100, 4'h0, 4'b0100, rd4(1, 2, 9, 4), 4'b0100, 2'b00, 2, 0, 0);
        // FP and x0 destinations are exempt from the hazard rule
        applyStimulus(0, 4'b0011, 4'h0, 4'b0010, rd4(9, 9, 0, 0), 4'b0011, 2'b01, 0, 1, 0);
        applyStimulus(0, 4'b0011, 4'h0, 4'h0, rd4(0, 0, 0, 0), 4'b0011, 2'b00, 0, 1, 0);
        // Port limit with four high-priority requests
        applyStimulus(0, 4'hF, 4'hF, 4'h0, rd4(1, 2, 3, 4), 4'b0011, 2'b11, 0, 1, 0);
        // Mid-run reset returns the round-robin pointer to 0
        applyStimulus(1, 4'hF, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b0000, 2'b00, 0, 0, 0);
        applyStimulus(0, 4'hF, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b0011, 2'b11, 0, 1, 0);
        applyStimulus(0, 4'h0, 4'h0, 4'h0, rd4(1, 2, 3, 4), 4'b0000, 2'b00, 0, 0, 0);

        for (int w = 0; w < 10 && sbQ.size() > 0; w++) begin
            @(posedge clk);
        end
        @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
